// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-pass shift/rotate controller around a 16-bit barrel shifter.
// Counts beyond the shifter's per-pass range are split into successive passes.
module barrel_shifter #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic [N-1:0] data_i,
    input  logic [C-1:0] cnt_i,
    input  logic [1:0]   op_i,
    output logic [N-1:0] data_o
);
    logic [2*N-1:0] rl, rr;
    assign rl = {data_i, data_i} << cnt_i;
    assign rr = {data_i, data_i} >> cnt_i;
    always_comb data_o = op_i == 2'b00 ? rl[2*N-1:N] :
                         op_i == 2'b01 ? data_i << cnt_i :
                         op_i == 2'b10 ? rr[N-1:0] : data_i >> cnt_i;
endmodule

module shift_sequencer #(
    parameter int N = 16,
    parameter int C = 4,
    parameter int K = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_data,
    input  logic [K-1:0] req_cnt,
    input  logic [1:0]   req_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [K:0] NN   = (K+1)'(N);
    localparam logic [K:0] MAXS = (K+1)'(2**C - 1);
    state_e      state_q;
    logic [N-1:0] work_q, rsp_data_q, sh_out;
    logic [K:0]  rem_q, cnt_ext, acc_rem_d, step, rem_d;
    logic [1:0]  op_q;
    // op[0] set means zero-fill shift (saturates at N); clear means rotate (wraps mod N)
    always_comb begin
        cnt_ext   = {1'b0, req_cnt};
        acc_rem_d = req_op[0] ? (cnt_ext > NN ? NN : cnt_ext) : cnt_ext % NN;
        step      = rem_q > MAXS ? MAXS : rem_q;
        rem_d     = rem_q - step;
    end
    barrel_shifter #(.N(N), .C(C)) u_shifter (
        .data_i (work_q),
        .cnt_i  (step[C-1:0]),
        .op_i   (op_q),
        .data_o (sh_out)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
        end else if (state_q == IDLE) begin
            if (req_valid) begin
                work_q  <= req_data;
                op_q    <= req_op;
                rem_q   <= acc_rem_d;
                state_q <= acc_rem_d == '0 ? DONE : RUN;
                if (acc_rem_d == '0) rsp_data_q <= req_data;
            end
        end else if (state_q == RUN) begin
            work_q <= sh_out;
            rem_q  <= rem_d;
            if (rem_d == '0) begin
                state_q    <= DONE;
                rsp_data_q <= sh_out;
            end
        end else if (state_q == DONE) begin
            if (rsp_ready) state_q <= IDLE;
        end else begin
            state_q <= IDLE;
        end
    end
    assign req_ready = state_q == IDLE;
    assign rsp_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scenario tasks with a scoreboard of expected result and latency.
module tb_shift_sequencer;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_ready;
    logic [15:0] req_data = 0;
    logic [5:0]  req_cnt = 0;
    logic [1:0]  req_op = 0;
    logic        rsp_valid, rsp_ready = 0;
    logic [15:0] rsp_data;
    logic        busy;
    int checks = 0, failures = 0;

    typedef struct packed { logic [15:0] data; int lat; } exp_t;
    exp_t exp_q[$];

    shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_cnt(req_cnt), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [15:0] d, logic [5:0] c, logic [1:0] op);
        int r;
        exp_t e;
        r = op[0] ? (c > 16 ? 16 : int'(c)) : int'(c) % 16;
        case (op)
            2'b00: e.data = (d << r) | (d >> (16 - r));
            2'b01: e.data = d << r;
            2'b10: e.data = (d >> r) | (d << (16 - r));
            default: e.data = d >> r;
        endcase
        e.lat = (r + 14) / 15 + 1;
        return e;
    endfunction

    task automatic send(input logic [15:0] d, input logic [5:0] c, input logic [1:0] op);
        int t = 0;
        while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout req_ready=%0b required=1", req_ready);
        end
        req_data = d; req_cnt = c; req_op = op; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) n = -1;
    endtask

    task automatic handshake;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        req_valid = 1; req_data = 16'h5555; req_cnt = 6'd3; req_op = 2'b00;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b001 || rsp_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_state valid/busy/ready=%b data=%h required 001/0000", {rsp_valid, busy, req_ready}, rsp_data);
        end
        req_valid = 0;
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_ignores_req busy=%b required=0", busy); end
    endtask

    task automatic test_shift_left;
        int n; exp_t e;
        exp_q.push_back('{16'h0010, 2});
        send(16'h8001, 6'd4, 2'b01);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL shl_busy busy=%b valid=%b required 1/0", busy, rsp_valid); end
        wait_rsp(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.lat) begin failures++; $display("FAIL shl_latency got=%0d required=%0d", n, e.lat); end
        checks++;
        if (rsp_data !== e.data || busy !== 1'b1) begin failures++; $display("FAIL shl_data got=%h busy=%b required=%h busy=1", rsp_data, busy, e.data); end
        handshake();
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin failures++; $display("FAIL shl_release valid/busy/ready=%b required=001", {rsp_valid, busy, req_ready}); end
    endtask

    task automatic test_rotate_left;
        int n; exp_t e;
        exp_q.push_back('{16'h2341, 2});
        exp_q.push_back('{16'h1234, 1});
        for (int i = 0; i < 2; i++) begin
            send(16'h1234, i == 0 ? 6'd20 : 6'd16, 2'b00);
            wait_rsp(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.lat || rsp_data !== e.data) begin
                failures++;
                $display("FAIL rol_%0d lat=%0d data=%h required lat=%0d data=%h", i, n, rsp_data, e.lat, e.data);
            end
            handshake();
        end
    endtask

    task automatic test_saturate;
        int n; exp_t e;
        exp_q.push_back('{16'h0000, 3});
        exp_q.push_back('{16'h0000, 3});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send(16'hFFFF, 6'd40, 2'b11);
            else send(16'h00F0, 6'd17, 2'b01);
            wait_rsp(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.lat || rsp_data !== e.data) begin
                failures++;
                $display("FAIL saturate_%0d lat=%0d data=%h required lat=%0d data=%h", i, n, rsp_data, e.lat, e.data);
            end
            handshake();
        end
    endtask

    task automatic test_rotate_right;
        int n; exp_t e;
        exp_q.push_back('{16'hABCD, 1});
        exp_q.push_back('{16'hF000, 2});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send(16'hABCD, 6'd0, 2'b10);
            else send(16'h000F, 6'd4, 2'b10);
            wait_rsp(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.lat || rsp_data !== e.data) begin
                failures++;
                $display("FAIL ror_%0d lat=%0d data=%h required lat=%0d data=%h", i, n, rsp_data, e.lat, e.data);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure;
        int n, bad = 0; exp_t e;
        exp_q.push_back('{16'h2341, 2});
        exp_q.push_back('{16'hF000, 2});
        send(16'h1234, 6'd4, 2'b00);
        wait_rsp(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.lat || rsp_data !== e.data) begin failures++; $display("FAIL bp_first lat=%0d data=%h required lat=%0d data=%h", n, rsp_data, e.lat, e.data); end
        req_data = 16'h000F; req_cnt = 6'd4; req_op = 2'b10; req_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 16'h2341) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d required=0", bad); end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, busy, req_ready} !== 3'b001) begin failures++; $display("FAIL bp_no_turnaround valid/busy/ready=%b required=001", {rsp_valid, busy, req_ready}); end
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL bp_second_accept busy=%b required=1", busy); end
        wait_rsp(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.lat || rsp_data !== e.data) begin failures++; $display("FAIL bp_second lat=%0d data=%h required lat=%0d data=%h", n, rsp_data, e.lat, e.data); end
        handshake();
    endtask

    task automatic test_reset_mid_run;
        int n, seen = 0; exp_t e;
        send(16'h8001, 6'd16, 2'b01);
        #3 rst_n = 0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'h0) begin
            failures++;
            $display("FAIL midrun_reset valid=%b busy=%b data=%h required 0/0/0000", rsp_valid, busy, rsp_data);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midrun_dropped rsp_cycles=%0d required=0", seen); end
        exp_q.push_back('{16'h0000, 3});
        send(16'h00F0, 6'd17, 2'b01);
        wait_rsp(n);
        e = exp_q.pop_front();
        checks++;
        if (n !== e.lat || rsp_data !== e.data) begin failures++; $display("FAIL midrun_recover lat=%0d data=%h required lat=%0d data=%h", n, rsp_data, e.lat, e.data); end
        handshake();
    endtask

    task automatic test_random;
        int n; exp_t e;
        logic [15:0] d; logic [5:0] c; logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom); c = 6'($urandom); op = 2'($urandom);
            exp_q.push_back(model(d, c, op));
            send(d, c, op);
            req_data = ~d; req_cnt = ~c; req_op = ~op;
            wait_rsp(n);
            e = exp_q.pop_front();
            checks++;
            if (n !== e.lat || rsp_data !== e.data) begin
                failures++;
                $display("FAIL random_%0d d=%h c=%0d op=%b lat=%0d data=%h required lat=%0d data=%h", i, d, c, op, n, rsp_data, e.lat, e.data);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1 handshake();
        end
    endtask

    initial begin
        test_reset();
        test_shift_left();
        test_rotate_left();
        test_saturate();
        test_rotate_right();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that wraps one 16-bit barrelShifter instance. It performs shifts and rotates by counts larger than the shifter's 0..15 range by issuing repeated passes through the shifter. It sits between an issuing unit (valid/ready request) and a consumer (valid/ready response), and holds one operation at a time.

Parameters:
N, 16, data width; must equal the barrelShifter data width.
C, 4, barrelShifter count width; maximum per-pass step is 2^C-1 = 15.
K, 6, request count width; requested counts range 0..2^K-1 = 63.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
req_valid  input  1  request present.
req_ready  output  1  high only in IDLE; the request is accepted on an edge where req_valid and req_ready are both high.
req_data  input  N  operand.
req_cnt  input  K  requested shift/rotate amount.
req_op  input  2  00 rotate left, 01 shift left (zero fill), 10 rotate right, 11 shift right logical (zero fill).
rsp_valid  output  1  result available; high only in DONE.
rsp_ready  input  1  consumer accepts the result.
rsp_data  output  N  result; registered; stable while rsp_valid is high.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, RUN, DONE. Registers:
  - work register (N bits)
  - remaining count rem (K+1 bits)
  - op (2 bits)
- Reset (rst_n low, any state, including mid-RUN or DONE):
  - state goes to IDLE; rsp_valid=0, rsp_data=0, work=0, rem=0, busy=0.
  - The in-flight operation is dropped and no response is produced.
  - req_valid is ignored while rst_n is low.
- Accept edge (IDLE, req_valid & req_ready):
  - work <= req_data; op <= req_op.
  - Rotate ops: rem <= req_cnt mod N.
  - Shift ops: rem <= min(req_cnt, N). Counts at or above N saturate, so the result is all zeros.
  - If the reduced rem is 0: next state is DONE, and rsp_data <= req_data. Otherwise: next state is RUN.
- RUN, one pass per cycle:
  - step = min(rem, 2^C-1).
  - The shifter is driven with In=work, Cnt=step[C-1:0], Op=op.
  - On the edge: work <= shifter Out; rem <= rem - step.
  - If rem - step == 0: state <= DONE and rsp_data <= shifter Out.
- Pass count P = ceil(rem/15). Worst cases: P=2 for shifts (16 = 15+1); P=1 for rotates (rem is at most 15).
- Latency: rsp_valid rises after the (P+1)-th rising edge, counting the accept edge as the first. With P=0, it is high the cycle right after the accept edge.
- DONE:
  - rsp_valid=1; rsp_data is held.
  - On an edge with rsp_ready=1: state <= IDLE and rsp_valid falls.
  - rsp_data keeps its last value after handshake; it is only meaningful while rsp_valid is high.
- No same-cycle turnaround. req_ready is low during DONE, including the response-handshake cycle, so a new request is accepted no earlier than the cycle after the response handshake.
- req_valid asserted during RUN/DONE is ignored (req_ready=0). The requester must hold its request until accepted.
- Changes on req_data/req_cnt/req_op after acceptance have no effect.
- Composition: successive zero-fill shifts and successive rotates compose additively. This is what makes multi-pass results equal to a single shift/rotate by the full count.
- Shifter Op encoding is passed straight through. The shifter must implement 10 as rotate right, consistent with this block's op table.
- Arithmetic: rem subtraction never underflows (step <= rem). The comparison against zero uses full K+1 bits.

Test Plan:
- Shift left, one pass: req 0x8001, op 01, cnt 4 -> rsp_data 0x0010; P=1; rsp_valid high after the 2nd edge; busy high from the accept edge until the response handshake.
- Rotate left, count reduced mod N: req 0x1234, op 00, cnt 20 -> rem 4, P=1, rsp_data 0x2341. Then cnt 16 on the same data -> P=0, rsp_data 0x1234 the cycle after accept.
- Saturated logical right shift: req 0xFFFF, op 11, cnt 40 -> rem 16, passes 15 then 1. After the first pass work=0x0001; rsp_data 0x0000 after the 3rd edge. Also op 01, cnt 17 on 0x00F0 -> passes 15 then 1 (first pass 0x0000) -> 0x0000.
- Zero count and rotate right: req 0xABCD, op 10, cnt 0 -> rsp_data 0xABCD with no RUN cycle. Then req 0x000F, op 10, cnt 4 -> 0xF000.
- Backpressure: hold rsp_ready low 5 cycles in DONE while driving a second req_valid -> rsp_data stable, req_ready=0, second request not taken. Raise rsp_ready -> back to IDLE, then the second request is accepted on the following edge.
- Reset mid-operation: assert rst_n low during the RUN cycle of a cnt=16 shift, asynchronously between edges -> rsp_valid and busy go 0 immediately, rsp_data=0, and no response ever appears. After release, a new request completes normally.
